// File: rtl/cam_pkg.sv
// Shared camera-interface definitions: frame FSM states and default timing,
// used by both the transmit and capture sides.
package cam_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBP,
    ST_ACTIVE,
    ST_HBLANK,
    ST_VFP
  } cam_state_t;

  localparam int CAM_H_ACTIVE  = 640;
  localparam int CAM_V_ACTIVE  = 480;
  localparam int CAM_VSYNC_LEN = 3;
  localparam int CAM_VBP       = 17;
  localparam int CAM_HBLANK    = 5;
  localparam int CAM_VFP       = 10;

  function automatic int cam_max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Bits needed for a counter that runs 0 .. n-1 (at least one bit).
  function automatic int cam_cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cam_tx.sv
// Camera-style parallel transmitter: frames RGB565 pixels from an external
// first-word-fall-through source into a vsync / href / byte stream.
//
// state     | meaning
// ----------+--------------------------------------------------------
// ST_IDLE   | no frame; waits for i_en
// ST_VSYNC  | vsync pulse, VSYNC_LEN cycles
// ST_VBP    | back porch before the first row, VBP cycles
// ST_ACTIVE | href high, 2*H_ACTIVE bytes, high byte of each pixel first
// ST_HBLANK | href low between rows, HBLANK cycles
// ST_VFP    | front porch after the last row; i_en decides restart
module cam_tx
  import cam_pkg::*;
#(
  parameter int H_ACTIVE  = CAM_H_ACTIVE,
  parameter int V_ACTIVE  = CAM_V_ACTIVE,
  parameter int VSYNC_LEN = CAM_VSYNC_LEN,
  parameter int VBP       = CAM_VBP,
  parameter int HBLANK    = CAM_HBLANK,
  parameter int VFP       = CAM_VFP
) (
  input  logic        i_pclk,
  input  logic        i_rstn,
  input  logic        i_en,
  input  logic        i_pix_valid,
  input  logic [15:0] i_pix_data,
  output logic        o_pix_rd,
  output logic        o_vsync,
  output logic        o_href,
  output logic [7:0]  o_data,
  output logic        o_sof,
  output logic        o_underrun
);

  localparam int BYTES = 2 * H_ACTIVE;
  localparam int BW    = cam_cnt_w(BYTES);
  localparam int RW    = cam_cnt_w(V_ACTIVE);
  localparam int PW    = cam_cnt_w(cam_max4(VSYNC_LEN, VBP, HBLANK, VFP));

  localparam logic [BW-1:0] BYTE_LAST   = BW'(BYTES - 1);
  localparam logic [RW-1:0] ROW_LAST    = RW'(V_ACTIVE - 1);
  localparam logic [PW-1:0] VSYNC_LAST  = PW'(VSYNC_LEN - 1);
  localparam logic [PW-1:0] VBP_LAST    = PW'(VBP - 1);
  localparam logic [PW-1:0] HBLANK_LAST = PW'(HBLANK - 1);
  localparam logic [PW-1:0] VFP_LAST    = PW'(VFP - 1);

  cam_state_t    state, state_nx;
  logic [BW-1:0] byte_cnt, byte_nx;
  logic [RW-1:0] row_cnt, row_nx;
  logic [PW-1:0] porch_cnt, porch_nx;
  logic [15:0]   hold, hold_d;
  logic [7:0]    data_d;
  logic          vsync_d, href_d, sof_d, under_d;
  logic          hi_slot;
  logic          in_porch;

  // Outputs are registered from the next state so that they line up with it.
  always_ff @(posedge i_pclk or negedge i_rstn) begin
    if (!i_rstn) begin
      state      <= ST_IDLE;
      byte_cnt   <= '0;
      row_cnt    <= '0;
      porch_cnt  <= '0;
      hold       <= '0;
      o_vsync    <= 1'b0;
      o_href     <= 1'b0;
      o_data     <= 8'h00;
      o_sof      <= 1'b0;
      o_underrun <= 1'b0;
    end else begin
      state      <= state_nx;
      byte_cnt   <= byte_nx;
      row_cnt    <= row_nx;
      porch_cnt  <= porch_nx;
      hold       <= hold_d;
      o_vsync    <= vsync_d;
      o_href     <= href_d;
      o_data     <= data_d;
      o_sof      <= sof_d;
      o_underrun <= under_d;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (i_en) state_nx = ST_VSYNC;
      ST_VSYNC:  if (porch_cnt == VSYNC_LAST) state_nx = ST_VBP;
      ST_VBP:    if (porch_cnt == VBP_LAST) state_nx = ST_ACTIVE;
      ST_ACTIVE: if (byte_cnt == BYTE_LAST)
                   state_nx = (row_cnt < ROW_LAST) ? ST_HBLANK : ST_VFP;
      ST_HBLANK: if (porch_cnt == HBLANK_LAST) state_nx = ST_ACTIVE;
      ST_VFP:    if (porch_cnt == VFP_LAST) state_nx = i_en ? ST_VSYNC : ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase

    in_porch = (state == ST_VSYNC) || (state == ST_VBP) ||
               (state == ST_HBLANK) || (state == ST_VFP);

    byte_nx  = ((state == ST_ACTIVE) && (state_nx == ST_ACTIVE)) ? byte_cnt + BW'(1) : '0;
    porch_nx = (in_porch && (state_nx == state)) ? porch_cnt + PW'(1) : '0;

    // Row count spans ACTIVE/HBLANK and clears once the frame leaves ACTIVE.
    row_nx = row_cnt;
    if ((state == ST_ACTIVE) && (state_nx == ST_HBLANK)) row_nx = row_cnt + RW'(1);
    else if ((state == ST_ACTIVE) && (state_nx == ST_VFP)) row_nx = '0;
  end

  always_comb begin
    hi_slot  = (state_nx == ST_ACTIVE) && !byte_nx[0];
    o_pix_rd = hi_slot && i_pix_valid;
    hold_d   = hold;
    data_d   = 8'h00;
    under_d  = 1'b0;
    if (hi_slot) begin
      if (i_pix_valid) begin
        hold_d = i_pix_data;
        data_d = i_pix_data[15:8];
      end else begin
        // Starved slot: send a black pixel and keep the timing intact.
        hold_d  = '0;
        under_d = 1'b1;
      end
    end else if (state_nx == ST_ACTIVE) begin
      data_d = hold[7:0];
    end
    vsync_d = (state_nx == ST_VSYNC);
    href_d  = (state_nx == ST_ACTIVE);
    sof_d   = (state_nx == ST_VSYNC) && (state != ST_VSYNC);
  end

endmodule

// File: tb/tb_cam_tx.sv
// Bench for cam_tx on a 4x2 frame: a cycle-offset timing model checks sync and
// href, and a byte scoreboard fed from the pixel source checks the data.
module tb_cam_tx;

  localparam int H     = 4;
  localparam int V     = 2;
  localparam int VS    = 3;
  localparam int VB    = 17;
  localparam int HB    = 5;
  localparam int FP    = 10;
  localparam int ROW   = 2 * H + HB;
  localparam int A0    = VS + VB;
  localparam int FRAME = VS + VB + V * 2 * H + (V - 1) * HB + FP;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic        pix_rd;
  logic        vsync;
  logic        href;
  logic [7:0]  data;
  logic        sof;
  logic        underrun;

  cam_tx #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .VSYNC_LEN(VS),
    .VBP      (VB),
    .HBLANK   (HB),
    .VFP      (FP)
  ) dut (
    .i_pclk     (clk),
    .i_rstn     (rstn),
    .i_en       (en),
    .i_pix_valid(pix_valid),
    .i_pix_data (pix_data),
    .o_pix_rd   (pix_rd),
    .o_vsync    (vsync),
    .o_href     (href),
    .o_data     (data),
    .o_sof      (sof),
    .o_underrun (underrun)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int off = 0;
  int pix_idx = 0;
  int drop_slot = -1;
  bit in_frame = 1'b0;
  bit pop_pend = 1'b0;
  bit und_pend = 1'b0;
  int n_rd = 0;
  int n_under = 0;
  int n_bytes = 0;
  int n_sof = 0;
  logic [7:0] sb[$];
  logic [7:0] rx[$];

  function automatic logic [15:0] pix_word(input int i);
    return 16'(32'h1234 + i * 32'h4444);
  endfunction

  function automatic bit m_href(input int o);
    int k;
    if (o < A0) return 1'b0;
    k = o - A0;
    return ((k / ROW) < V) && ((k % ROW) < 2 * H);
  endfunction

  // The cycle before a high byte appears is the one in which the pixel is read.
  function automatic bit m_slot(input int o);
    return m_href(o + 1) && ((((o + 1 - A0) % ROW) % 2) == 0);
  endfunction

  function automatic int slot_num(input int o);
    int k;
    k = o + 1 - A0;
    return (k / ROW) * H + (k % ROW) / 2;
  endfunction

  // One pixel clock: FIFO source update, model compare, scoreboard push.
  task automatic tick();
    logic [7:0]  exp_b;
    logic [15:0] w;
    bit          slot;
    @(negedge clk);
    cyc++;
    if (pop_pend) pix_idx++;
    pop_pend = 1'b0;
    pix_data = pix_word(pix_idx);
    if (sof === 1'b1) begin
      n_sof++;
      if (in_frame) begin
        n_vec++;
        if (off + 1 < FRAME) begin
          n_err++;
          $display("FAIL sof_early: sof after %0d cycles, frame needs %0d", off + 1, FRAME);
        end
      end
      off = 0;
      in_frame = 1'b1;
    end else if (in_frame) begin
      off++;
    end
    if (href === 1'b1) begin
      n_bytes++;
      rx.push_back(data);
    end
    if (underrun === 1'b1) n_under++;
    if (in_frame) begin
      n_vec++;
      if (vsync !== 1'(off < VS)) begin
        n_err++;
        $display("FAIL vsync_timing: off=%0d got %b expected %b", off, vsync, (off < VS));
      end
      n_vec++;
      if (href !== m_href(off)) begin
        n_err++;
        $display("FAIL href_timing: off=%0d got %b expected %b", off, href, m_href(off));
      end
      n_vec++;
      if (href === 1'b1) begin
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL data_extra: off=%0d got %h with no byte expected", off, data);
        end else begin
          exp_b = sb.pop_front();
          if (data !== exp_b) begin
            n_err++;
            $display("FAIL data_byte: off=%0d got %h expected %h", off, data, exp_b);
          end
        end
      end else if (data !== 8'h00) begin
        n_err++;
        $display("FAIL data_idle: off=%0d got %h expected 00", off, data);
      end
      n_vec++;
      if (underrun !== und_pend) begin
        n_err++;
        $display("FAIL underrun_pulse: off=%0d got %b expected %b", off, underrun, und_pend);
      end
    end
    und_pend = 1'b0;
    slot = in_frame && m_slot(off);
    pix_valid = 1'b1;
    if (slot) begin
      if (slot_num(off) == drop_slot) begin
        pix_valid = 1'b0;
        sb.push_back(8'h00);
        sb.push_back(8'h00);
        und_pend = 1'b1;
      end else begin
        w = pix_word(pix_idx);
        sb.push_back(w[15:8]);
        sb.push_back(w[7:0]);
      end
    end
    #1;
    if (in_frame) begin
      n_vec++;
      if (pix_rd !== (slot && pix_valid)) begin
        n_err++;
        $display("FAIL pix_rd: off=%0d got %b expected %b", off, pix_rd, (slot && pix_valid));
      end
    end
    if (pix_rd === 1'b1) begin
      pop_pend = 1'b1;
      n_rd++;
    end
    #1;
  endtask

  task automatic clear_counts();
    n_rd = 0;
    n_under = 0;
    n_bytes = 0;
    n_sof = 0;
    rx.delete();
  endtask

  task automatic wait_sof(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      tick();
      if (sof === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    en = 1'b1;
    repeat (3) tick();
    n_vec++;
    if ({vsync, href, sof, underrun, pix_rd} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b expected 00000", {vsync, href, sof, underrun, pix_rd});
    end
    n_vec++;
    if (data !== 8'h00) begin
      n_err++;
      $display("FAIL reset_data: got %h expected 00", data);
    end
    clear_counts();
    rstn = 1'b1;
    n_vec++;
    if (vsync !== 1'b0) begin
      n_err++;
      $display("FAIL release_vsync_early: got %b expected 0", vsync);
    end
    tick();
    n_vec++;
    if ({vsync, sof} !== 2'b11) begin
      n_err++;
      $display("FAIL release_vsync_sof: got %b expected 11", {vsync, sof});
    end
    en = 1'b0;
    repeat (FRAME + 10) tick();
    n_vec++;
    if (n_bytes != 2 * H * V) begin
      n_err++;
      $display("FAIL reset_frame_bytes: got %0d expected %0d", n_bytes, 2 * H * V);
    end
  endtask

  task automatic test_small_frame();
    bit ok;
    clear_counts();
    pix_idx = 0;
    en = 1'b1;
    wait_sof(5, ok);
    en = 1'b0;
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL small_sof_timeout: got no sof expected one within 5 cycles");
    end
    repeat (FRAME + 10) tick();
    n_vec++;
    if (n_rd != H * V) begin
      n_err++;
      $display("FAIL small_rd_count: got %0d expected %0d", n_rd, H * V);
    end
    n_vec++;
    if (n_bytes != 2 * H * V || n_under != 0 || sb.size() != 0) begin
      n_err++;
      $display("FAIL small_totals: bytes %0d under %0d left %0d expected %0d 0 0",
               n_bytes, n_under, sb.size(), 2 * H * V);
    end
    n_vec++;
    if (rx.size() < 4) begin
      n_err++;
      $display("FAIL small_first_bytes: got %0d bytes expected at least 4", rx.size());
    end else if ({rx[0], rx[1], rx[2], rx[3]} !== 32'h12345678) begin
      n_err++;
      $display("FAIL small_first_bytes: got %h%h%h%h expected 12345678", rx[0], rx[1], rx[2], rx[3]);
    end
  endtask

  task automatic test_underrun();
    bit ok;
    clear_counts();
    pix_idx = 0;
    drop_slot = 2;
    en = 1'b1;
    wait_sof(5, ok);
    en = 1'b0;
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL under_sof_timeout: got no sof expected one within 5 cycles");
    end
    repeat (FRAME + 10) tick();
    drop_slot = -1;
    n_vec++;
    if (n_rd != H * V - 1 || n_under != 1) begin
      n_err++;
      $display("FAIL under_counts: rd %0d under %0d expected %0d 1", n_rd, n_under, H * V - 1);
    end
    n_vec++;
    if (n_bytes != 2 * H * V || sb.size() != 0) begin
      n_err++;
      $display("FAIL under_bytes: got %0d left %0d expected %0d 0", n_bytes, sb.size(), 2 * H * V);
    end
    n_vec++;
    if (rx.size() < 8) begin
      n_err++;
      $display("FAIL under_slot_bytes: got %0d bytes expected at least 8", rx.size());
    end else if ({rx[4], rx[5], rx[6], rx[7]} !== 32'h00009abc) begin
      n_err++;
      $display("FAIL under_slot_bytes: got %h%h%h%h expected 00009abc", rx[4], rx[5], rx[6], rx[7]);
    end
  endtask

  task automatic test_en_drop();
    bit ok;
    bit seen;
    clear_counts();
    pix_idx = 0;
    en = 1'b1;
    wait_sof(5, ok);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick();
      if (href === 1'b1) seen = 1'b1;
    end
    en = 1'b0;
    n_vec++;
    if (!(ok && seen)) begin
      n_err++;
      $display("FAIL endrop_start: got sof %b href %b expected 1 1", ok, seen);
    end
    repeat (2 * FRAME) tick();
    n_vec++;
    if ({vsync, href} !== 2'b00) begin
      n_err++;
      $display("FAIL endrop_idle: got %b expected 00", {vsync, href});
    end
    n_vec++;
    if (n_sof != 1 || n_bytes != 2 * H * V) begin
      n_err++;
      $display("FAIL endrop_frame: sof %0d bytes %0d expected 1 %0d", n_sof, n_bytes, 2 * H * V);
    end
  endtask

  task automatic test_reset_mid_row();
    bit ok;
    bit seen;
    clear_counts();
    pix_idx = 0;
    en = 1'b1;
    wait_sof(5, ok);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick();
      if (href === 1'b1) seen = 1'b1;
    end
    repeat (3) tick();
    n_vec++;
    if (href !== 1'b1) begin
      n_err++;
      $display("FAIL midrow_precond: href got %b expected 1", href);
    end
    rstn = 1'b0;
    #1;
    n_vec++;
    if ({vsync, href, pix_rd} !== 3'b000 || data !== 8'h00) begin
      n_err++;
      $display("FAIL midrow_async_clear: ctrl %b data %h expected 000 00", {vsync, href, pix_rd}, data);
    end
    pop_pend = 1'b0;
    und_pend = 1'b0;
    in_frame = 1'b0;
    sb.delete();
    tick();
    rstn = 1'b1;
    clear_counts();
    tick();
    n_vec++;
    if ({vsync, sof} !== 2'b11) begin
      n_err++;
      $display("FAIL midrow_restart: got %b expected 11", {vsync, sof});
    end
    en = 1'b0;
    repeat (FRAME + 10) tick();
    n_vec++;
    if (n_bytes != 2 * H * V || sb.size() != 0) begin
      n_err++;
      $display("FAIL midrow_frame: bytes %0d left %0d expected %0d 0", n_bytes, sb.size(), 2 * H * V);
    end
  endtask

  task automatic test_back_to_back();
    bit ok0, ok1, ok2;
    int t0, t1, t2;
    logic [15:0] got;
    clear_counts();
    pix_idx = 0;
    en = 1'b1;
    wait_sof(5, ok0);
    t0 = cyc;
    wait_sof(FRAME + 5, ok1);
    t1 = cyc;
    wait_sof(FRAME + 5, ok2);
    t2 = cyc;
    en = 1'b0;
    repeat (FRAME + 10) tick();
    n_vec++;
    if (!(ok0 && ok1 && ok2)) begin
      n_err++;
      $display("FAIL b2b_sof_timeout: got %b%b%b expected 111", ok0, ok1, ok2);
    end
    n_vec++;
    if (t1 - t0 != FRAME || t2 - t1 != FRAME) begin
      n_err++;
      $display("FAIL b2b_period: got %0d %0d expected %0d", t1 - t0, t2 - t1, FRAME);
    end
    n_vec++;
    if (n_sof != 3 || n_rd != 3 * H * V || rx.size() != 6 * H * V) begin
      n_err++;
      $display("FAIL b2b_counts: sof %0d rd %0d bytes %0d expected 3 %0d %0d",
               n_sof, n_rd, rx.size(), 3 * H * V, 6 * H * V);
    end
    for (int k = 0; k < 3 * H * V && 2 * k + 1 < rx.size(); k++) begin
      got = {rx[2 * k], rx[2 * k + 1]};
      n_vec++;
      if (got !== pix_word(k)) begin
        n_err++;
        $display("FAIL b2b_capture: pixel %0d got %h expected %h", k, got, pix_word(k));
      end
    end
  endtask

  initial begin
    rstn = 1'b0;
    en = 1'b0;
    pix_valid = 1'b1;
    pix_data = 16'h0000;
    test_reset();
    test_small_frame();
    test_underrun();
    test_en_drop();
    test_reset_mid_row();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
